// File: rtl/hsi_mse_pkg.sv
// Shared constants and pipeline sideband type for the HSI MSE datapath.
package hsi_mse_pkg;

   localparam int unsigned HM_DATA_WIDTH     = 8;
   localparam int unsigned HM_DATA_WIDTH_MUL = 2 * HM_DATA_WIDTH;
   localparam int unsigned HM_DATA_WIDTH_ACC = 24;
   localparam int unsigned HM_PAR_ELEMS      = 4;
   localparam int unsigned HM_COUNT_WIDTH    = 8;
   // Wide enough to hold a popcount of up to 16 lanes.
   localparam int unsigned HM_LANE_CNT_WIDTH = 5;

   // Per-beat control that travels alongside the lane data through the pipeline.
   typedef struct packed {
      logic                         valid;
      logic                         last;
      logic                         init_en;
      logic [HM_DATA_WIDTH_ACC-1:0] init_acc;
      logic [HM_LANE_CNT_WIDTH-1:0] lane_cnt;
   } beat_sb_t;

   function automatic logic [HM_LANE_CNT_WIDTH-1:0] popcount16(input logic [15:0] bits);
      logic [HM_LANE_CNT_WIDTH-1:0] cnt;
      cnt = '0;
      for (int i = 0; i < 16; i++) begin
         cnt = cnt + HM_LANE_CNT_WIDTH'(bits[i]);
      end
      return cnt;
   endfunction

endpackage

// File: rtl/sq_df_acc_par_if.sv
// Beat input / running-result output bundle of the parallel squared-difference accumulator.
interface sq_df_acc_par_if
   import hsi_mse_pkg::*;
#(
   parameter int unsigned DATA_WIDTH     = HM_DATA_WIDTH,
   parameter int unsigned DATA_WIDTH_ACC = HM_DATA_WIDTH_ACC,
   parameter int unsigned PAR_ELEMS      = HM_PAR_ELEMS,
   parameter int unsigned COUNT_WIDTH    = HM_COUNT_WIDTH
) ();

   logic                            clear;
   logic                            data_in_valid;
   logic                            data_in_last;
   logic                            initial_acc_en;
   logic [DATA_WIDTH_ACC-1:0]       initial_acc;
   logic [PAR_ELEMS-1:0]            lane_mask;
   logic [PAR_ELEMS*DATA_WIDTH-1:0] data_in_v1;
   logic [PAR_ELEMS*DATA_WIDTH-1:0] data_in_v2;

   logic                            data_out_valid;
   logic [DATA_WIDTH_ACC-1:0]       data_out;
   logic                            data_out_last;
   logic [COUNT_WIDTH-1:0]          data_out_count;
   logic                            overflow;

   modport master (
      output clear, data_in_valid, data_in_last, initial_acc_en, initial_acc, lane_mask,
             data_in_v1, data_in_v2,
      input  data_out_valid, data_out, data_out_last, data_out_count, overflow
   );

   modport slave (
      input  clear, data_in_valid, data_in_last, initial_acc_en, initial_acc, lane_mask,
             data_in_v1, data_in_v2,
      output data_out_valid, data_out, data_out_last, data_out_count, overflow
   );

endinterface

// File: rtl/sq_df_lane.sv
// One lane: registered masked |v1-v2| followed by a registered square.
module sq_df_lane
   import hsi_mse_pkg::*;
#(
   parameter int unsigned DATA_WIDTH     = HM_DATA_WIDTH,
   parameter int unsigned DATA_WIDTH_MUL = HM_DATA_WIDTH_MUL
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      mask,
   input  logic [DATA_WIDTH-1:0]     v1,
   input  logic [DATA_WIDTH-1:0]     v2,
   output logic [DATA_WIDTH_MUL-1:0] sq
);

   logic [DATA_WIDTH-1:0]     diff_q;
   logic [DATA_WIDTH_MUL-1:0] sq_q;

   // S1: absolute difference; a masked lane contributes zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         diff_q <= '0;
      end else if (!mask) begin
         diff_q <= '0;
      end else if (v1 >= v2) begin
         diff_q <= v1 - v2;
      end else begin
         diff_q <= v2 - v1;
      end
   end

   // S2: square of the registered difference.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sq_q <= '0;
      end else begin
         sq_q <= DATA_WIDTH_MUL'(diff_q) * DATA_WIDTH_MUL'(diff_q);
      end
   end

   assign sq = sq_q;

endmodule

// File: rtl/sq_df_acc_par.sv
// Multi-lane squared-difference accumulator: lanes -> registered adder tree -> per-vector acc.
module sq_df_acc_par
   import hsi_mse_pkg::*;
#(
   parameter int unsigned DATA_WIDTH     = HM_DATA_WIDTH,
   parameter int unsigned DATA_WIDTH_MUL = HM_DATA_WIDTH_MUL,
   parameter int unsigned DATA_WIDTH_ACC = HM_DATA_WIDTH_ACC,
   parameter int unsigned PAR_ELEMS      = HM_PAR_ELEMS,
   parameter int unsigned COUNT_WIDTH    = HM_COUNT_WIDTH,
   parameter bit          SATURATE       = 1'b1
) (
   input logic            clk,
   input logic            rst_n,
   sq_df_acc_par_if.slave bus
);

   localparam int unsigned LEVELS     = $clog2(PAR_ELEMS);
   localparam int unsigned TREE_WIDTH = DATA_WIDTH_MUL + LEVELS;
   localparam int unsigned SUM_WIDTH  = DATA_WIDTH_ACC + 1;
   // Sideband depth matches S1, S2 and every tree level.
   localparam int unsigned SB_DEPTH   = 2 + LEVELS;
   // Heap-ordered tree: node n has children 2n+1 and 2n+2; leaves start at PAR_ELEMS-1.
   localparam int unsigned NODES      = 2 * PAR_ELEMS - 1;

   logic [DATA_WIDTH_MUL-1:0] sq       [PAR_ELEMS];
   logic [TREE_WIDTH-1:0]     node_q   [PAR_ELEMS];
   logic [TREE_WIDTH-1:0]     node_all [NODES];

   beat_sb_t sb_in;
   beat_sb_t sb_q [SB_DEPTH];
   beat_sb_t tail;

   logic                      valid_q;
   logic                      last_q;
   logic [DATA_WIDTH_ACC-1:0] acc_q;
   logic [COUNT_WIDTH-1:0]    cnt_q;
   logic                      ovf_q;
   // Set while a vector is open, i.e. the next valid beat continues it.
   logic                      in_vec_q;

   logic [DATA_WIDTH_ACC-1:0] base;
   logic [SUM_WIDTH-1:0]      sum_ext;
   logic                      carry;
   logic [DATA_WIDTH_ACC-1:0] acc_next;
   logic [COUNT_WIDTH-1:0]    cnt_next;
   logic                      ovf_next;

   for (genvar i = 0; i < PAR_ELEMS; i++) begin : g_lane
      sq_df_lane #(
         .DATA_WIDTH     (DATA_WIDTH),
         .DATA_WIDTH_MUL (DATA_WIDTH_MUL)
      ) u_lane (
         .clk   (clk),
         .rst_n (rst_n),
         .mask  (bus.lane_mask[i]),
         .v1    (bus.data_in_v1[i*DATA_WIDTH +: DATA_WIDTH]),
         .v2    (bus.data_in_v2[i*DATA_WIDTH +: DATA_WIDTH]),
         .sq    (sq[i])
      );
   end

   // Flat view of the tree: registered internal nodes followed by the lane squares.
   always_comb begin
      for (int n = 0; n < NODES; n++) begin
         node_all[n] = '0;
      end
      for (int n = 0; n < PAR_ELEMS - 1; n++) begin
         node_all[n] = node_q[n];
      end
      for (int i = 0; i < PAR_ELEMS; i++) begin
         node_all[PAR_ELEMS - 1 + i] = TREE_WIDTH'(sq[i]);
      end
   end

   // Adder tree, one register per level; node_all[0] is the beat sum after LEVELS cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int n = 0; n < PAR_ELEMS; n++) begin
            node_q[n] <= '0;
         end
      end else begin
         for (int n = 0; n < PAR_ELEMS - 1; n++) begin
            node_q[n] <= node_all[2*n + 1] + node_all[2*n + 2];
         end
      end
   end

   // Sideband for the incoming beat; control inputs only matter when the beat is valid.
   always_comb begin
      sb_in       = '0;
      sb_in.valid = bus.data_in_valid;
      if (bus.data_in_valid) begin
         sb_in.last     = bus.data_in_last;
         sb_in.init_en  = bus.initial_acc_en;
         sb_in.init_acc = HM_DATA_WIDTH_ACC'(bus.initial_acc);
         sb_in.lane_cnt = popcount16(16'(bus.lane_mask));
      end
   end

   // Sideband shift register aligned with the lane and tree stages; clear drops everything.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < SB_DEPTH; k++) begin
            sb_q[k] <= '0;
         end
      end else if (bus.clear) begin
         for (int k = 0; k < SB_DEPTH; k++) begin
            sb_q[k] <= '0;
         end
      end else begin
         sb_q[0] <= sb_in;
         for (int k = 1; k < SB_DEPTH; k++) begin
            sb_q[k] <= sb_q[k-1];
         end
      end
   end

   assign tail = sb_q[SB_DEPTH-1];

   // Next accumulator state: seed on a vector start, carry-out flags overflow.
   always_comb begin
      if (in_vec_q) begin
         base = acc_q;
      end else if (tail.init_en) begin
         base = DATA_WIDTH_ACC'(tail.init_acc);
      end else begin
         base = '0;
      end
      sum_ext  = {1'b0, base} + SUM_WIDTH'(node_all[0]);
      carry    = sum_ext[DATA_WIDTH_ACC];
      acc_next = (carry && SATURATE) ? '1 : sum_ext[DATA_WIDTH_ACC-1:0];
      ovf_next = carry | (in_vec_q & ovf_q);
      cnt_next = (in_vec_q ? cnt_q : '0) + COUNT_WIDTH'(tail.lane_cnt);
   end

   // Accumulate stage; result registers hold their value through bubbles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q  <= 1'b0;
         last_q   <= 1'b0;
         acc_q    <= '0;
         cnt_q    <= '0;
         ovf_q    <= 1'b0;
         in_vec_q <= 1'b0;
      end else if (bus.clear) begin
         valid_q  <= 1'b0;
         last_q   <= 1'b0;
         acc_q    <= '0;
         cnt_q    <= '0;
         ovf_q    <= 1'b0;
         in_vec_q <= 1'b0;
      end else begin
         valid_q <= tail.valid;
         last_q  <= tail.valid & tail.last;
         if (tail.valid) begin
            acc_q    <= acc_next;
            cnt_q    <= cnt_next;
            ovf_q    <= ovf_next;
            in_vec_q <= ~tail.last;
         end
      end
   end

   assign bus.data_out_valid = valid_q;
   assign bus.data_out       = acc_q;
   assign bus.data_out_last  = last_q;
   assign bus.data_out_count = cnt_q;
   assign bus.overflow       = ovf_q;

endmodule

// File: tb/tb_sq_df_acc_par.sv
// Directed bench: a saturating and a wrapping instance see identical stimulus.
module tb_sq_df_acc_par;
   import hsi_mse_pkg::*;

   localparam int unsigned DW  = 8;
   localparam int unsigned ACC = 24;
   localparam int unsigned PAR = 4;
   localparam int unsigned CW  = 8;
   localparam int          LAT = 5;

   typedef struct {
      logic [ACC-1:0] d;
      logic [CW-1:0]  c;
      logic           l;
      logic           o;
      logic [ACC-1:0] dw;
      logic           ow;
      int             cyc;
   } rec_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   cyc   = 0;
   int   n_checks = 0;
   int   n_pass   = 0;
   rec_t q[$];

   always #5 clk = ~clk;

   sq_df_acc_par_if #(.DATA_WIDTH(DW), .DATA_WIDTH_ACC(ACC), .PAR_ELEMS(PAR),
                      .COUNT_WIDTH(CW)) bus_sat ();
   sq_df_acc_par_if #(.DATA_WIDTH(DW), .DATA_WIDTH_ACC(ACC), .PAR_ELEMS(PAR),
                      .COUNT_WIDTH(CW)) bus_wrap ();

   assign bus_wrap.clear          = bus_sat.clear;
   assign bus_wrap.data_in_valid  = bus_sat.data_in_valid;
   assign bus_wrap.data_in_last   = bus_sat.data_in_last;
   assign bus_wrap.initial_acc_en = bus_sat.initial_acc_en;
   assign bus_wrap.initial_acc    = bus_sat.initial_acc;
   assign bus_wrap.lane_mask      = bus_sat.lane_mask;
   assign bus_wrap.data_in_v1     = bus_sat.data_in_v1;
   assign bus_wrap.data_in_v2     = bus_sat.data_in_v2;

   sq_df_acc_par #(.DATA_WIDTH(DW), .DATA_WIDTH_MUL(2*DW), .DATA_WIDTH_ACC(ACC),
                   .PAR_ELEMS(PAR), .COUNT_WIDTH(CW), .SATURATE(1'b1)) u_dut_sat (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_sat)
   );

   sq_df_acc_par #(.DATA_WIDTH(DW), .DATA_WIDTH_MUL(2*DW), .DATA_WIDTH_ACC(ACC),
                   .PAR_ELEMS(PAR), .COUNT_WIDTH(CW), .SATURATE(1'b0)) u_dut_wrap (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_wrap)
   );

   always @(posedge clk) cyc <= cyc + 1;

   // Record every valid output, sampled mid-cycle.
   always @(negedge clk) begin
      rec_t r;
      if (bus_sat.data_out_valid) begin
         r.d   = bus_sat.data_out;
         r.c   = bus_sat.data_out_count;
         r.l   = bus_sat.data_out_last;
         r.o   = bus_sat.overflow;
         r.dw  = bus_wrap.data_out;
         r.ow  = bus_wrap.overflow;
         r.cyc = cyc;
         q.push_back(r);
      end
   end

   function automatic logic [31:0] p4(input int a0, input int a1, input int a2, input int a3);
      return {8'(a3), 8'(a2), 8'(a1), 8'(a0)};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      bus_sat.data_in_valid = 1'b0;
      repeat (n) step();
   endtask

   task automatic beat(input logic [31:0] v1, input logic [31:0] v2, input logic [3:0] mask,
                       input logic last, input logic init_en, input logic [ACC-1:0] init);
      bus_sat.data_in_v1     = v1;
      bus_sat.data_in_v2     = v2;
      bus_sat.lane_mask      = mask;
      bus_sat.data_in_last   = last;
      bus_sat.initial_acc_en = init_en;
      bus_sat.initial_acc    = init;
      bus_sat.data_in_valid  = 1'b1;
      step();
      bus_sat.data_in_valid  = 1'b0;
   endtask

   task automatic test_reset();
      bus_sat.clear          = 1'b0;
      bus_sat.data_in_valid  = 1'b0;
      bus_sat.data_in_last   = 1'b0;
      bus_sat.initial_acc_en = 1'b0;
      bus_sat.initial_acc    = '0;
      bus_sat.lane_mask      = '0;
      bus_sat.data_in_v1     = '0;
      bus_sat.data_in_v2     = '0;
      #1 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({bus_sat.data_out_valid, bus_sat.data_out, bus_sat.data_out_count,
           bus_sat.overflow, bus_sat.data_out_last} !== '0)
         $display("FAIL reset_state: got valid=%b data=%0d count=%0d ovf=%b, required all 0",
                  bus_sat.data_out_valid, bus_sat.data_out, bus_sat.data_out_count,
                  bus_sat.overflow);
      else n_pass++;
      #10 rst_n = 1'b1;
      step();
      for (int i = 0; i < 10; i++) begin
         step();
         n_checks++;
         if ({bus_sat.data_out_valid, bus_sat.data_out, bus_sat.overflow} !== '0)
            $display("FAIL reset_idle[%0d]: got valid=%b data=%0d ovf=%b, required 0/0/0", i,
                     bus_sat.data_out_valid, bus_sat.data_out, bus_sat.overflow);
         else n_pass++;
      end
   endtask

   task automatic test_single_beat();
      int t0;
      q.delete();
      t0 = cyc;
      beat(p4(10, 20, 30, 40), p4(7, 20, 35, 36), 4'hf, 1'b1, 1'b1, 24'd100);
      idle(8);
      n_checks++;
      if (q.size() != 1) $display("FAIL single_count: got %0d outputs, required 1", q.size());
      else n_pass++;
      n_checks++;
      if (q.size() < 1) $display("FAIL single_value: got no output, required 150");
      else if ({q[0].d, q[0].c, q[0].l, q[0].o} !== {24'd150, 8'd4, 1'b1, 1'b0})
         $display("FAIL single_value: got d=%0d c=%0d l=%b o=%b, required 150/4/1/0",
                  q[0].d, q[0].c, q[0].l, q[0].o);
      else n_pass++;
      n_checks++;
      if (q.size() < 1) $display("FAIL single_latency: got no output, required %0d", LAT);
      else if (q[0].cyc - t0 != LAT)
         $display("FAIL single_latency: got %0d, required %0d", q[0].cyc - t0, LAT);
      else n_pass++;
      n_checks++;
      if (q.size() < 1) $display("FAIL single_wrap: got no output, required 150");
      else if (q[0].dw !== 24'd150)
         $display("FAIL single_wrap: got %0d, required 150", q[0].dw);
      else n_pass++;
   endtask

   task automatic test_multi_beat();
      logic [ACC-1:0] ed [3] = '{24'd30, 24'd55, 24'd159};
      logic [CW-1:0]  ec [3] = '{8'd4, 8'd6, 8'd10};
      logic           el [3] = '{1'b0, 1'b0, 1'b1};
      q.delete();
      beat(p4(1, 2, 3, 4), p4(0, 0, 0, 0), 4'hf, 1'b0, 1'b0, 24'd0);
      // initial_acc_en mid-vector must be ignored.
      beat(p4(5, 5, 5, 5), p4(1, 2, 3, 4), 4'b0011, 1'b0, 1'b1, 24'd999);
      beat(p4(10, 0, 0, 0), p4(0, 0, 0, 2), 4'hf, 1'b1, 1'b0, 24'd0);
      idle(8);
      n_checks++;
      if (q.size() != 3) $display("FAIL multi_count: got %0d outputs, required 3", q.size());
      else n_pass++;
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (i >= q.size()) $display("FAIL multi[%0d]: got no output, required %0d", i, ed[i]);
         else if ({q[i].d, q[i].c, q[i].l} !== {ed[i], ec[i], el[i]})
            $display("FAIL multi[%0d]: got d=%0d c=%0d l=%b, required %0d/%0d/%b", i,
                     q[i].d, q[i].c, q[i].l, ed[i], ec[i], el[i]);
         else n_pass++;
      end
   endtask

   task automatic test_back_to_back();
      logic [ACC-1:0] ed [4] = '{24'd11, 24'd20, 24'd9, 24'd45};
      logic [CW-1:0]  ec [4] = '{8'd4, 8'd8, 8'd4, 8'd8};
      logic           el [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
      q.delete();
      beat(p4(2, 0, 0, 0), p4(0, 0, 0, 0), 4'hf, 1'b0, 1'b1, 24'd7);
      beat(p4(0, 3, 0, 0), p4(0, 0, 0, 0), 4'hf, 1'b1, 1'b0, 24'd0);
      beat(p4(1, 1, 1, 1), p4(0, 0, 0, 0), 4'hf, 1'b0, 1'b1, 24'd5);
      beat(p4(0, 0, 0, 6), p4(0, 0, 0, 0), 4'hf, 1'b1, 1'b0, 24'd0);
      idle(8);
      n_checks++;
      if (q.size() != 4) $display("FAIL b2b_count: got %0d outputs, required 4", q.size());
      else n_pass++;
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (i >= q.size()) $display("FAIL b2b[%0d]: got no output, required %0d", i, ed[i]);
         else if ({q[i].d, q[i].c, q[i].l} !== {ed[i], ec[i], el[i]})
            $display("FAIL b2b[%0d]: got d=%0d c=%0d l=%b, required %0d/%0d/%b", i,
                     q[i].d, q[i].c, q[i].l, ed[i], ec[i], el[i]);
         else n_pass++;
      end
      n_checks++;
      if (q.size() < 4) $display("FAIL b2b_gap: got %0d outputs, required 4", q.size());
      else if (q[3].cyc - q[0].cyc != 3)
         $display("FAIL b2b_gap: got span %0d cycles, required 3", q[3].cyc - q[0].cyc);
      else n_pass++;
   endtask

   task automatic test_saturation();
      logic [ACC-1:0] ed  [4] = '{24'hffffff, 24'hffffff, 24'hffffff, 24'd1};
      logic [ACC-1:0] edw [4] = '{24'd6, 24'd6, 24'd7, 24'd1};
      logic [CW-1:0]  ec  [4] = '{8'd4, 8'd4, 8'd8, 8'd4};
      logic           eo  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
      q.delete();
      beat(p4(4, 0, 0, 0), p4(0, 0, 0, 0), 4'hf, 1'b0, 1'b1, 24'd16777206);
      beat(p4(9, 9, 9, 9), p4(0, 0, 0, 0), 4'h0, 1'b0, 1'b0, 24'd0);
      beat(p4(1, 0, 0, 0), p4(0, 0, 0, 0), 4'hf, 1'b1, 1'b0, 24'd0);
      beat(p4(1, 0, 0, 0), p4(0, 0, 0, 0), 4'hf, 1'b1, 1'b0, 24'd0);
      idle(8);
      n_checks++;
      if (q.size() != 4) $display("FAIL sat_count: got %0d outputs, required 4", q.size());
      else n_pass++;
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (i >= q.size()) $display("FAIL sat[%0d]: got no output, required %0d", i, ed[i]);
         else if ({q[i].d, q[i].c, q[i].o} !== {ed[i], ec[i], eo[i]})
            $display("FAIL sat[%0d]: got d=%0h c=%0d o=%b, required %0h/%0d/%b", i,
                     q[i].d, q[i].c, q[i].o, ed[i], ec[i], eo[i]);
         else n_pass++;
         n_checks++;
         if (i >= q.size()) $display("FAIL wrap[%0d]: got no output, required %0d", i, edw[i]);
         else if ({q[i].dw, q[i].ow} !== {edw[i], eo[i]})
            $display("FAIL wrap[%0d]: got d=%0d o=%b, required %0d/%b", i,
                     q[i].dw, q[i].ow, edw[i], eo[i]);
         else n_pass++;
      end
   endtask

   task automatic test_clear();
      q.delete();
      beat(p4(3, 0, 0, 0), p4(0, 0, 0, 0), 4'hf, 1'b0, 1'b0, 24'd0);
      idle(7);
      beat(p4(7, 0, 0, 0), p4(0, 0, 0, 0), 4'hf, 1'b0, 1'b0, 24'd0);
      beat(p4(0, 7, 0, 0), p4(0, 0, 0, 0), 4'hf, 1'b0, 1'b0, 24'd0);
      // Clear together with a valid beat: the beat is dropped too.
      bus_sat.clear = 1'b1;
      beat(p4(8, 0, 0, 0), p4(0, 0, 0, 0), 4'hf, 1'b1, 1'b0, 24'd0);
      bus_sat.clear = 1'b0;
      idle(2);
      beat(p4(2, 0, 0, 0), p4(0, 0, 0, 0), 4'hf, 1'b1, 1'b0, 24'd0);
      idle(8);
      n_checks++;
      if (q.size() != 2) $display("FAIL clear_count: got %0d outputs, required 2", q.size());
      else n_pass++;
      n_checks++;
      if (q.size() < 1) $display("FAIL clear_pre: got no output, required 9");
      else if ({q[0].d, q[0].c, q[0].l} !== {24'd9, 8'd4, 1'b0})
         $display("FAIL clear_pre: got d=%0d c=%0d l=%b, required 9/4/0",
                  q[0].d, q[0].c, q[0].l);
      else n_pass++;
      n_checks++;
      if (q.size() < 2) $display("FAIL clear_post: got %0d outputs, required 2", q.size());
      else if ({q[1].d, q[1].c, q[1].l, q[1].o} !== {24'd4, 8'd4, 1'b1, 1'b0})
         $display("FAIL clear_post: got d=%0d c=%0d l=%b o=%b, required 4/4/1/0",
                  q[1].d, q[1].c, q[1].l, q[1].o);
      else n_pass++;
      n_checks++;
      if ({bus_sat.data_out_valid, bus_sat.data_out} !== {1'b0, 24'd4})
         $display("FAIL hold: got valid=%b data=%0d, required 0/4",
                  bus_sat.data_out_valid, bus_sat.data_out);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      q.delete();
      beat(p4(0, 0, 2, 0), p4(0, 0, 0, 0), 4'hf, 1'b0, 1'b1, 24'd3);
      idle(7);
      beat(p4(0, 0, 0, 9), p4(0, 0, 0, 0), 4'hf, 1'b0, 1'b0, 24'd0);
      step();
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({bus_sat.data_out_valid, bus_sat.data_out, bus_sat.data_out_count,
           bus_sat.overflow} !== '0)
         $display("FAIL rst_mid_state: got valid=%b data=%0d count=%0d, required all 0",
                  bus_sat.data_out_valid, bus_sat.data_out, bus_sat.data_out_count);
      else n_pass++;
      #3 rst_n = 1'b1;
      step();
      idle(2);
      beat(p4(0, 5, 0, 0), p4(0, 0, 0, 0), 4'hf, 1'b1, 1'b0, 24'd0);
      idle(8);
      n_checks++;
      if (q.size() != 2) $display("FAIL rst_mid_count: got %0d outputs, required 2", q.size());
      else n_pass++;
      n_checks++;
      if (q.size() < 1) $display("FAIL rst_mid_pre: got no output, required 7");
      else if ({q[0].d, q[0].c} !== {24'd7, 8'd4})
         $display("FAIL rst_mid_pre: got d=%0d c=%0d, required 7/4", q[0].d, q[0].c);
      else n_pass++;
      n_checks++;
      if (q.size() < 2) $display("FAIL rst_mid_post: got %0d outputs, required 2", q.size());
      else if ({q[1].d, q[1].c, q[1].l} !== {24'd25, 8'd4, 1'b1})
         $display("FAIL rst_mid_post: got d=%0d c=%0d l=%b, required 25/4/1",
                  q[1].d, q[1].c, q[1].l);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_single_beat();
      test_multi_beat();
      test_back_to_back();
      test_saturation();
      test_clear();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
